// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_defs: shared state encoding, bus width defaults and strobe levels for mem_bus_arbiter.
package mem_bus_defs;
    localparam int ADDR_W_DEF = 54;
    localparam int DATA_W_DEF = 64;
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_ADDR  = 3'd1;
    localparam state_t S_READ  = 3'd2;
    localparam state_t S_WRITE = 3'd3;
    localparam state_t S_ACK   = 3'd4;
    localparam logic STROBE_OFF = 1'b1;
endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// mba_rr_arbiter: combinational 2-way grant (0 = fetch, 1 = load/store).
// Round-robin on last_grant by default; MBA_FIXED_PRIO_EN gives port 1 fixed priority.
module mba_rr_arbiter (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic grant
);
    assign valid = req0 | req1;
`ifdef MBA_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign grant = req1;
`else
    assign grant = (req0 & req1) ? ~last_grant : req1;
`endif
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: sequences the multiplexed address/data memory bus for fetch and load/store ports.
// Build option MBA_FIXED_PRIO_EN selects fixed port-1 priority instead of round-robin.
module mem_bus_arbiter
    import mem_bus_defs::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              Req0,
    input  logic              Req1,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic              Wr1,
    input  logic [DATA_W-1:0] WData1,
    output logic              Ack0,
    output logic              Ack1,
    output logic [DATA_W-1:0] RData,
    inout  wire  [DATA_W-1:0] Data,
    output logic              nME,
    output logic              nALE,
    output logic              RnW,
    output logic              nOE
);
    state_t            state;
    logic [3:0]        cnt;
    logic              gnt, wr, last_grant;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              arb_valid, arb_grant;

    mba_rr_arbiter u_arb (
        .req0       (Req0),
        .req1       (Req1),
        .last_grant (last_grant),
        .valid      (arb_valid),
        .grant      (arb_grant)
    );

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            gnt        <= 1'b0;
            wr         <= 1'b0;
            last_grant <= 1'b1;
            addr       <= '0;
            wdata      <= '0;
            RData      <= '0;
        end else begin
            case (state)
                S_IDLE: if (arb_valid) begin
                    state      <= S_ADDR;
                    gnt        <= arb_grant;
                    last_grant <= arb_grant;
                    wr         <= arb_grant & Wr1;
                    addr       <= arb_grant ? Addr1 : Addr0;
                    wdata      <= WData1;
                end
                S_ADDR: begin
                    state <= wr ? S_WRITE : S_READ;
                    cnt   <= 4'(WAIT_CYCLES);
                end
                S_READ, S_WRITE: if (cnt == '0) begin
                    state <= S_ACK;
                    if (state == S_READ) RData <= Data;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes and acks are decoded straight from state so reset releases the bus on the same edge.
    assign nME  = (state == S_IDLE || state == S_ACK) ? STROBE_OFF : ~STROBE_OFF;
    assign nALE = state != S_ADDR;
    assign nOE  = state != S_READ;
    assign RnW  = !((state == S_ADDR || state == S_WRITE) && wr);
    assign Ack0 = state == S_ACK && !gnt;
    assign Ack1 = state == S_ACK && gnt;
    assign Data = state == S_ADDR ? DATA_W'(addr) : state == S_WRITE ? wdata : 'z;
endmodule
